// File: rtl/vram_arbiter.sv
// Shares a single-port synchronous-read video RAM between VGA pixel fetch and a CPU port.
// Display owns the RAM in the active window; CPU req/ack transactions run during blanking.
module vram_arbiter #(
    parameter logic [9:0]  HSTART = 10'd143,
    parameter logic [9:0]  VSTART = 10'd35,
    parameter int unsigned SCALE  = 2,
    parameter int unsigned FB_W   = 160,
    parameter int unsigned FB_H   = 120,
    parameter int unsigned AW     = 15,
    parameter int unsigned DW     = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [9:0]    i_x,
    input  logic [9:0]    i_y,
    input  logic          i_blank_n,
    input  logic          i_cpu_req,
    input  logic          i_cpu_we,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [DW-1:0] i_cpu_wdata,
    output logic          o_cpu_ack,
    output logic [DW-1:0] o_cpu_rdata,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_we,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_pix_valid,
    output logic [DW-1:0] o_pix_data
);

    localparam int unsigned CW       = 10;
    localparam int unsigned LW       = 2 * CW;
    localparam int unsigned FB_CELLS = FB_W * FB_H;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RCAP = 2'd1,
        S_WACK = 2'd2,
        S_RACK = 2'd3
    } state_t;

    state_t        r_state;
    logic          r_ack;
    logic [DW-1:0] r_rdata;
    logic          r_pix_valid;
    logic          r_oob;

    logic [CW-1:0] w_dx;
    logic [CW-1:0] w_dy;
    logic [CW-1:0] w_col;
    logic [CW-1:0] w_row;
    logic [LW-1:0] w_lin;
    logic [AW-1:0] w_disp_addr;
    logic          w_in_range;
    logic          w_issue;

    // Beam position to framebuffer cell, each cell replicated 2^SCALE in x and y
    assign w_dx        = i_x - HSTART;
    assign w_dy        = i_y - VSTART;
    assign w_col       = w_dx >> SCALE;
    assign w_row       = w_dy >> SCALE;
    assign w_lin       = LW'(w_row) * LW'(FB_W) + LW'(w_col);
    assign w_disp_addr = AW'(w_lin);

    assign w_in_range  = 32'(i_cpu_addr) < FB_CELLS;
    assign w_issue     = (r_state == S_IDLE) && i_cpu_req && !i_blank_n;

    // Display always wins the address bus while the beam is visible
    assign o_mem_addr  = i_blank_n ? w_disp_addr : i_cpu_addr;
    assign o_mem_we    = i_rst && w_issue && i_cpu_we && w_in_range;
    assign o_mem_wdata = i_cpu_wdata;

    assign o_cpu_ack   = r_ack;
    assign o_cpu_rdata = r_rdata;
    assign o_pix_valid = r_pix_valid;
    assign o_pix_data  = r_pix_valid ? i_mem_rdata : '0;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state     <= S_IDLE;
            r_ack       <= 1'b0;
            r_rdata     <= '0;
            r_pix_valid <= 1'b0;
            r_oob       <= 1'b0;
        end else begin
            r_pix_valid <= i_blank_n;
            r_ack       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_oob   <= !w_in_range;
                        r_ack   <= i_cpu_we;
                        r_state <= i_cpu_we ? S_WACK : S_RCAP;
                    end
                end
                // Read was issued last cycle, so finish even if the window opened
                S_RCAP: begin
                    r_rdata <= r_oob ? '0 : i_mem_rdata;
                    r_ack   <= 1'b1;
                    r_state <= S_RACK;
                end
                S_WACK, S_RACK: r_state <= S_IDLE;
                default:        r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter with a synchronous-read RAM model.
module tb_vram_arbiter;

    logic        clk;
    logic        rst;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        blank_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        pix_valid;
    logic [7:0]  pix_data;

    int checks   = 0;
    int failures = 0;

    vram_arbiter dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_x         (x),
        .i_y         (y),
        .i_blank_n   (blank_n),
        .i_cpu_req   (cpu_req),
        .i_cpu_we    (cpu_we),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_wdata (cpu_wdata),
        .o_cpu_ack   (cpu_ack),
        .o_cpu_rdata (cpu_rdata),
        .o_mem_addr  (mem_addr),
        .o_mem_we    (mem_we),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .o_pix_valid (pix_valid),
        .o_pix_data  (pix_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int a);
        return 8'(a) ^ 8'h5A;
    endfunction

    // RAM model: unwritten cells read back a fixed pattern of their address
    bit [7:0] mem [0:32767];
    bit       wr  [0:32767];
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wr[mem_addr]  <= 1'b1;
        end
        mem_rdata <= wr[mem_addr] ? mem[mem_addr] : pat(int'(mem_addr));
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        blank_n;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [14:0] exp_addr;
        logic        exp_valid;
        logic [7:0]  exp_pix;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{1'b1, 10'd143, 10'd35,  15'd0,     1'b1, pat(0)};
        vecs[1] = '{1'b1, 10'd147, 10'd35,  15'd1,     1'b1, pat(1)};
        vecs[2] = '{1'b1, 10'd143, 10'd39,  15'd160,   1'b1, pat(160)};
        vecs[3] = '{1'b1, 10'd777, 10'd514, 15'd19198, 1'b1, pat(19198)};
        vecs[4] = '{1'b1, 10'd150, 10'd40,  15'd161,   1'b1, pat(161)};
        vecs[5] = '{1'b0, 10'd0,   10'd0,   15'd0,     1'b0, 8'h00};

        rst = 1'b0; x = '0; y = '0; blank_n = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd5; cpu_wdata = 8'h77;

        // Reset with a pending blanked write: no write enable, no ack
        #1;
        chk("rst_we_comb", 32'(mem_we), 32'd0);
        tick;
        tick;
        chk("rst_ack", 32'(cpu_ack), 32'd0);
        chk("rst_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        cpu_req = 1'b0;
        rst = 1'b1;
        tick;

        // Display address and pixel path
        for (int i = 0; i < 6; i++) begin
            blank_n = vecs[i].blank_n;
            x = vecs[i].x;
            y = vecs[i].y;
            #1;
            if (vecs[i].blank_n) begin
                chk($sformatf("disp_addr[%0d]", i), 32'(mem_addr), 32'(vecs[i].exp_addr));
                chk($sformatf("disp_we[%0d]", i), 32'(mem_we), 32'd0);
            end
            tick;
            chk($sformatf("pix_valid[%0d]", i), 32'(pix_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("pix_data[%0d]", i), 32'(pix_data), 32'(vecs[i].exp_pix));
        end

        // Blanked write then back-to-back read of the same cell
        blank_n = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd1234; cpu_wdata = 8'hA5;
        #1;
        chk("wr_we_issue", 32'(mem_we), 32'd1);
        chk("wr_addr_issue", 32'(mem_addr), 32'd1234);
        tick;
        chk("wr_ack_t1", 32'(cpu_ack), 32'd1);
        chk("wr_we_t1", 32'(mem_we), 32'd0);
        tick;
        chk("wr_ack_t2", 32'(cpu_ack), 32'd0);
        cpu_we = 1'b0;
        #1;
        chk("rd_we_issue", 32'(mem_we), 32'd0);
        tick;
        chk("rd_ack_t1", 32'(cpu_ack), 32'd0);
        tick;
        chk("rd_ack_t2", 32'(cpu_ack), 32'd1);
        chk("rd_data", 32'(cpu_rdata), 32'hA5);
        cpu_req = 1'b0;
        tick;
        chk("rd_ack_end", 32'(cpu_ack), 32'd0);
        chk("rd_data_hold", 32'(cpu_rdata), 32'hA5);

        // Request during the active window waits for blanking
        blank_n = 1'b1; x = 10'd143; y = 10'd35;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd100; cpu_wdata = 8'h3C;
        for (int i = 0; i < 50; i++) begin
            #1;
            chk($sformatf("wait_we[%0d]", i), 32'(mem_we), 32'd0);
            chk($sformatf("wait_ack[%0d]", i), 32'(cpu_ack), 32'd0);
            tick;
        end
        blank_n = 1'b0;
        #1;
        chk("wait_we_service", 32'(mem_we), 32'd1);
        tick;
        chk("wait_ack_service", 32'(cpu_ack), 32'd1);
        cpu_req = 1'b0;
        tick;

        // Read issued on the last blank cycle completes after the window opens
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'd100;
        x = 10'd147; y = 10'd39;
        #1;
        chk("edge_rd_addr", 32'(mem_addr), 32'd100);
        tick;
        blank_n = 1'b1;
        #1;
        chk("edge_disp_addr", 32'(mem_addr), 32'd161);
        chk("edge_we", 32'(mem_we), 32'd0);
        chk("edge_ack_t1", 32'(cpu_ack), 32'd0);
        tick;
        chk("edge_ack_t2", 32'(cpu_ack), 32'd1);
        chk("edge_rdata", 32'(cpu_rdata), 32'h3C);
        chk("edge_pix_data", 32'(pix_data), 32'(pat(161)));
        cpu_req = 1'b0;
        tick;
        chk("edge_ack_end", 32'(cpu_ack), 32'd0);

        // Out-of-range write is dropped but acked; out-of-range read returns zero
        blank_n = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd19200; cpu_wdata = 8'hFF;
        #1;
        chk("oob_we", 32'(mem_we), 32'd0);
        chk("oob_addr", 32'(mem_addr), 32'd19200);
        tick;
        chk("oob_wr_ack", 32'(cpu_ack), 32'd1);
        tick;
        cpu_we = 1'b0;
        tick;
        chk("oob_rd_ack_t1", 32'(cpu_ack), 32'd0);
        tick;
        chk("oob_rd_ack_t2", 32'(cpu_ack), 32'd1);
        chk("oob_rdata", 32'(cpu_rdata), 32'd0);
        cpu_req = 1'b0;
        tick;

        // Reset held three cycles while a read sits in capture
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'd1234;
        tick;
        tick;
        chk("pre_rst_rdata", 32'(cpu_rdata), 32'hA5);
        cpu_req = 1'b0;
        tick;
        cpu_req = 1'b1;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk($sformatf("mid_rst_ack[%0d]", i), 32'(cpu_ack), 32'd0);
            chk($sformatf("mid_rst_we[%0d]", i), 32'(mem_we), 32'd0);
            chk($sformatf("mid_rst_rdata[%0d]", i), 32'(cpu_rdata), 32'd0);
        end
        cpu_req = 1'b0;
        rst = 1'b1;
        tick;
        chk("post_rst_ack", 32'(cpu_ack), 32'd0);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd7; cpu_wdata = 8'h11;
        #1;
        chk("post_rst_idle_we", 32'(mem_we), 32'd1);
        tick;
        chk("post_rst_ack_t1", 32'(cpu_ack), 32'd1);
        cpu_req = 1'b0;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port, synchronous-read video RAM between two users: the VGA pixel fetch, driven by the timing generator's x/y/blank outputs, and a CPU load/store port.
- Display fetch owns the RAM whenever the beam is in the active window. CPU accesses are served only during blanking, through a req/ack handshake.
- Sits between the VGA timing generator, the framebuffer RAM and the CPU memory-mapped I/O decoder.

Parameters:
- HSTART, 10'd143: horizontal counter value of the first active pixel.
- VSTART, 10'd35: vertical counter value of the first active line.
- SCALE, 2: log2 of the pixel-replication factor (each framebuffer cell covers 4x4 screen pixels).
- FB_W, 160: framebuffer width in cells.
- FB_H, 120: framebuffer height in cells.
- AW, 15: RAM/CPU address width.
- DW, 8: RAM data width.

Ports:
- i_clk  in  1  system/pixel clock.
- i_rst  in  1  synchronous, active-low reset.
- i_x  in  10  horizontal counter from the timing generator.
- i_y  in  10  vertical counter from the timing generator.
- i_blank_n  in  1  active-window flag from the timing generator (1 = visible).
- i_cpu_req  in  1  CPU transaction request; held with addr/we/wdata until o_cpu_ack.
- i_cpu_we  in  1  1 = write, 0 = read.
- i_cpu_addr  in  AW  linear framebuffer cell address.
- i_cpu_wdata  in  DW  write data.
- o_cpu_ack  out  1  one-cycle completion pulse.
- o_cpu_rdata  out  DW  read data, valid while o_cpu_ack=1.
- o_mem_addr  out  AW  RAM address.
- o_mem_we  out  1  RAM write enable.
- o_mem_wdata  out  DW  RAM write data.
- i_mem_rdata  in  DW  RAM read data, one cycle after the address.
- o_pix_valid  out  1  i_blank_n delayed by one cycle.
- o_pix_data  out  DW  pixel for the (x,y) presented one cycle earlier; 0 when o_pix_valid=0.

Behaviour:
- Reset (i_rst=0 at an edge):
  - state goes to IDLE; o_cpu_ack, o_cpu_rdata and o_pix_valid go to 0.
  - o_mem_we=0 combinationally while i_rst=0.
  - An in-flight CPU transaction is aborted with no ack. The CPU must re-issue it.
- Display address, computed combinationally: ((i_y-VSTART)>>SCALE)*FB_W + ((i_x-HSTART)>>SCALE), truncated to AW.
- Grant rule: if i_blank_n=1, o_mem_addr is the display address and o_mem_we=0, in every state.
- FSM states and transitions:
  - IDLE: if i_cpu_req=1 and i_blank_n=0, the access is issued this cycle.
    - o_mem_addr=i_cpu_addr and o_mem_wdata=i_cpu_wdata.
    - o_mem_we=i_cpu_we, but only if i_cpu_addr < FB_W*FB_H.
    - Next state is WACK for a write, RCAP for a read.
    - With no request, or while blanked-in, stay in IDLE.
  - RCAP: capture data into the rdata register: i_mem_rdata, or 0 if the address was out of range. Then go to RACK. This state completes even if i_blank_n has risen, because the read was already issued.
  - WACK / RACK: o_cpu_ack=1 for one cycle. Go to IDLE.
- Latency:
  - Write: issue at cycle t, ack at t+1.
  - Read: issue at t, ack and data at t+2.
- Handshake:
  - The requester samples ack and must deassert i_cpu_req, or present a new transaction, in the cycle after ack.
  - IDLE accepts a new request in that cycle.
  - o_cpu_rdata holds its value until the next read capture.
- Out-of-range CPU address (>= FB_W*FB_H):
  - Write is suppressed but still acked.
  - Read returns 0.
- Pixel path:
  - o_pix_valid <= i_blank_n on every edge.
  - o_pix_data = o_pix_valid ? i_mem_rdata : 0.
  - The downstream must delay hs/vs by one cycle to stay aligned.
- Simultaneous events:
  - Request in the same cycle i_blank_n rises: display wins and the CPU waits.
  - Request in the same cycle i_blank_n falls: the CPU access is issued that cycle.

Test Plan:
- Reset held low 3 cycles mid-read (state RCAP), then released -> o_cpu_ack never pulses, o_cpu_rdata=0, o_mem_we=0 during reset, state IDLE after release.
- i_blank_n=1 with (x,y) = (143,35), (147,35), (143,39), (777,514) -> o_mem_addr = 0, 1, 160, 19198 respectively. o_pix_data on the next cycle equals the RAM model contents at those addresses.
- Blanking, CPU write addr=1234, data=8'hA5 -> o_mem_we=1 for exactly 1 cycle, ack at t+1. A following read of 1234 returns 8'hA5 with ack at t+2.
- CPU request raised while i_blank_n=1 for 50 cycles -> no ack and o_mem_we=0 throughout. Service starts in the first cycle i_blank_n=0.
- Read issued on the last blank cycle, then i_blank_n rises -> RCAP completes, ack at t+2 with the correct data, and display addresses are driven from t+1.
- CPU write addr=19200, data=8'hFF -> ack at t+1, o_mem_we stays 0. A read of 19200 returns 8'h00.
